// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared types and constants for the TPL DAC DMA elastic buffer.
package ad_ip_jesd204_tpl_dac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int UFLOW_CNT_W = 16;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Storage, wrap-bit pointers, full/empty and registered occupancy for the DMA buffer.
module ad_ip_jesd204_tpl_dac_dma_fifo
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int W          = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wr_data,
  output logic [W-1:0]          rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int PW    = ptr_w(DEPTH_LOG2);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          push_ok, pop_ok;

  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr[PW-2:0]];

  always_comb begin
    wr_nxt = wr_ptr + {{(PW-1){1'b0}}, push_ok};
    rd_nxt = rd_ptr + {{(PW-1){1'b0}}, pop_ok};
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      fill_level <= wr_nxt - rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-2:0]] <= wr_data;
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_buffer.sv
// Prefilling elastic buffer feeding the TPL DAC channel; zero-fills and flags underflow.
// Optional underflow counter: AD_IP_JESD204_TPL_DAC_DMA_BUFFER_UFLOW_CNT_EN.
module ad_ip_jesd204_tpl_dac_dma_buffer
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PREFILL_LEVEL   = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] s_data,
  output logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] dma_data,
  output logic                                       dma_valid,
  output logic                                       underflow,
  input  logic                                       underflow_clr,
  output logic [FIFO_DEPTH_LOG2:0]                   fill_level
`ifdef AD_IP_JESD204_TPL_DAC_DMA_BUFFER_UFLOW_CNT_EN
  ,
  output logic [UFLOW_CNT_W-1:0]                     underflow_count
`endif
);

  localparam int W  = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam int PW = ptr_w(FIFO_DEPTH_LOG2);
  localparam logic [PW-1:0] PREFILL_LVL = PW'(PREFILL_LEVEL);

  state_t        state, state_nxt;
  logic          full, empty, push, pop, flush, uflow_hit;
  logic [W-1:0]  rd_data;
  logic [PW-1:0] fill_nxt;

  assign s_ready   = enable && !full && (state != IDLE);
  assign push      = s_valid && s_ready;
  assign pop       = enable && (state == RUN) && !empty;
  assign flush     = !enable || (state == IDLE);
  assign uflow_hit = enable && (state == RUN) && empty;
  // Occupancy after this cycle's push, so RUN starts the cycle the level is reached.
  assign fill_nxt  = fill_level + {{(PW-1){1'b0}}, push};

  ad_ip_jesd204_tpl_dac_dma_fifo #(
    .W          (W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) i_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .wr_data    (s_data),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (empty),
    .fill_level (fill_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PREFILL;
        PREFILL: if (fill_nxt >= PREFILL_LVL) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_data  <= '0;
      dma_valid <= 1'b0;
    end else if (pop) begin
      dma_data  <= rd_data;
      dma_valid <= 1'b1;
    end else begin
      dma_data  <= '0;
      dma_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              underflow <= 1'b0;
    else if (uflow_hit)     underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

`ifdef AD_IP_JESD204_TPL_DAC_DMA_BUFFER_UFLOW_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_count <= '0;
    end else if (uflow_hit) begin
      if (underflow_clr)              underflow_count <= UFLOW_CNT_W'(1);
      else if (underflow_count != '1) underflow_count <= underflow_count + 1'b1;
    end else if (underflow_clr) begin
      underflow_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_buffer.sv
// Directed bench with a word scoreboard for the TPL DAC DMA buffer.
module tb_ad_ip_jesd204_tpl_dac_dma_buffer;
  import ad_ip_jesd204_tpl_dac_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, enable, s_valid, s_ready, dma_valid, underflow, underflow_clr;
  logic [W-1:0] s_data, dma_data;
  logic [4:0]   fill_level;

  logic         bp_enable, bp_s_valid, bp_s_ready, bp_dma_valid, bp_underflow, bp_underflow_clr;
  logic [W-1:0] bp_s_data, bp_dma_data;
  logic [4:0]   bp_fill_level;
`ifdef AD_IP_JESD204_TPL_DAC_DMA_BUFFER_UFLOW_CNT_EN
  logic [15:0]  underflow_count, bp_underflow_count;
`endif

  int           checks = 0, passed = 0, fails = 0;
  logic [W-1:0] sb [$];
  logic         last_acc, acc, ok;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .dma_data      (dma_data),
    .dma_valid     (dma_valid),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .fill_level    (fill_level)
`ifdef AD_IP_JESD204_TPL_DAC_DMA_BUFFER_UFLOW_CNT_EN
    , .underflow_count (underflow_count)
`endif
  );

  ad_ip_jesd204_tpl_dac_dma_buffer #(.PREFILL_LEVEL(16)) dut_bp (
    .clk           (clk),
    .reset         (reset),
    .enable        (bp_enable),
    .s_valid       (bp_s_valid),
    .s_ready       (bp_s_ready),
    .s_data        (bp_s_data),
    .dma_data      (bp_dma_data),
    .dma_valid     (bp_dma_valid),
    .underflow     (bp_underflow),
    .underflow_clr (bp_underflow_clr),
    .fill_level    (bp_fill_level)
`ifdef AD_IP_JESD204_TPL_DAC_DMA_BUFFER_UFLOW_CNT_EN
    , .underflow_count (bp_underflow_count)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // One cycle of the main DUT: score the output word, record any handshake.
  task automatic step();
    @(negedge clk);
    if (dma_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL sb_underrun: observed %0h expected no word", dma_data);
      end else begin
        chk("sb_data", dma_data, sb.pop_front());
      end
    end else begin
      chk("dma_zero", dma_data, '0);
    end
    last_acc = enable && s_valid && s_ready;
    if (last_acc) sb.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_acc) return;
    end
    fail_now("push_timeout");
  endtask

  task automatic bp_step(output logic a);
    @(negedge clk);
    a = bp_s_valid && bp_s_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; underflow_clr = 1'b0;
    bp_enable = 1'b0; bp_s_valid = 1'b0; bp_s_data = '0; bp_underflow_clr = 1'b0;

    // Reset and idle
    #12;
    chk("rst_dma_data", dma_data, '0);
    chk("rst_dma_valid", dma_valid, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_fill", fill_level, 5'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_s_ready", s_ready, 1'b0);
      chk("idle_state", dut.state, IDLE);
    end

    // Prefill 1..8, keep streaming afterwards
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    chk("pf_fill", fill_level, 5'd8);
    chk("pf_state", dut.state, RUN);
    chk("pf_valid_n1", dma_valid, 1'b0);
    s_data = 9;
    step();
    chk("pf_valid_n2", dma_valid, 1'b1);
    chk("pf_first_word", dma_data, 64'd1);

    // Steady stream
    for (int i = 0; i < 1000; i++) begin
      s_data = W'(10 + i);
      step();
      chk("ss_fill", fill_level, 5'd8);
      chk("ss_underflow", underflow, 1'b0);
      chk("ss_valid", dma_valid, 1'b1);
    end

    // Underflow: 20 more words then stop
    for (int i = 0; i < 20; i++) begin
      s_data = W'(1010 + i);
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fill_level == 0) break;
      step();
    end
    chk("uf_empty", fill_level, 5'd0);
    chk("uf_last_valid", dma_valid, 1'b1);
    step();
    chk("uf_valid", dma_valid, 1'b0);
    chk("uf_data", dma_data, '0);
    chk("uf_flag", underflow, 1'b1);
    chk("uf_state", dut.state, RUN);
    chk("uf_sb_drained", sb.size(), 0);
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = W'(2000 + i);
      step();
      chk("uf_resume_state", dut.state, RUN);
    end
    chk("uf_resume_valid", dma_valid, 1'b1);

    // Disable keeps the sticky flag; clear drops it
    enable = 1'b0; s_valid = 1'b0;
    step();
    sb.delete();
    chk("dis_fill", fill_level, 5'd0);
    chk("dis_valid", dma_valid, 1'b0);
    chk("dis_state", dut.state, IDLE);
    chk("dis_uf_sticky", underflow, 1'b1);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uf_clr", underflow, 1'b0);

    // Fresh prefill, then drop enable at fill_level 5
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) push_word(W'(100 + i));
    chk("re_pf_state", dut.state, PREFILL);
    chk("re_pf_fill", fill_level, 5'd3);
    chk("re_pf_valid", dma_valid, 1'b0);
    for (int i = 4; i <= 8; i++) push_word(W'(100 + i));
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fill_level == 5) break;
      step();
    end
    chk("mid_fill5", fill_level, 5'd5);
    chk("mid_state", dut.state, RUN);
    enable = 1'b0;
    step();
    sb.delete();
    chk("mid_fill0", fill_level, 5'd0);
    chk("mid_valid", dma_valid, 1'b0);
    chk("mid_data", dma_data, '0);
    chk("mid_state_idle", dut.state, IDLE);
    chk("mid_s_ready", s_ready, 1'b0);
    enable = 1'b1;
    step();
    chk("again_state", dut.state, PREFILL);
    chk("again_fill", fill_level, 5'd0);
    step();
    chk("again_no_run", dut.state, PREFILL);
    chk("again_valid", dma_valid, 1'b0);
    enable = 1'b0;

    // Backpressure: PREFILL_LEVEL=16 fills the FIFO before any pop
    bp_enable = 1'b1; bp_s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bp_s_data = W'(500 + i);
      ok = 1'b0;
      for (int j = 0; j < 10; j++) begin
        bp_step(acc);
        if (acc) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("bp_push_timeout");
    end
    chk("bp_fill16", bp_fill_level, 5'd16);
    chk("bp_s_ready_full", bp_s_ready, 1'b0);
    chk("bp_state", dut_bp.state, RUN);
    bp_s_data = 64'd999;
    bp_step(acc);
    chk("bp_17th_rejected", acc, 1'b0);
    chk("bp_fill15", bp_fill_level, 5'd15);
    chk("bp_first_valid", bp_dma_valid, 1'b1);
    chk("bp_first_word", bp_dma_data, 64'd500);
    bp_s_valid = 1'b0; bp_enable = 1'b0;
    bp_step(acc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
